rv_lsu: RTL and testbench

Load/store sequencer between the single-cycle core's decode/execute stage and a handshaked data-memory bus. It consumes `mem_read`, `mem_write` and `mem_op` from the instruction controller, plus the ALU address and rs2 data. It then runs a multi-cycle bus transaction, stalling the core until the access retires. It generates byte enables, replicates store data, and sign- or zero-extends load data. Misaligned or illegal accesses and bus timeouts are reported as one-cycle pulses.

---
 rtl/rv_lsu_if.sv | 22 ++
 rtl/rv_lsu.sv | 186 ++++++++++++++++++
 tb/tb_rv_lsu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_lsu_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// Request fields are held stable by the master until bus_gnt.
interface rv_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/rv_lsu.sv
// Load/store sequencer: runs one handshaked bus access per load/store and
// stalls the core until it retires. Reports illegal accesses and timeouts.
module rv_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  rv_lsu_if.master    bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvld_q, rvld_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;

  logic        access, is_rd, op_bad, expired;
  logic [3:0]  be_new;
  logic [31:0] wd_new, lane, ld_ext;

  assign access  = mem_read | mem_write;
  assign is_rd   = mem_read;
  assign expired = (cnt_q >= CNT_LAST);

  // Legality, lane enables and store replication of the incoming access.
  always_comb begin
    op_bad = 1'b0;
    case (mem_op)
      3'b000:  op_bad = 1'b0;
      3'b001:  op_bad = addr[0];
      3'b010:  op_bad = |addr[1:0];
      3'b100:  op_bad = ~is_rd;
      3'b101:  op_bad = ~is_rd | addr[0];
      default: op_bad = 1'b1;
    endcase
    case (mem_op[1:0])
      2'b00: begin
        be_new = 4'b0001 << addr[1:0];
        wd_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new = 4'b0011 << {addr[1], 1'b0};
        wd_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new = 4'b1111;
        wd_new = wdata;
      end
    endcase
  end

  always_comb begin
    lane = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'b0, lane[7:0]};
      3'b101:  ld_ext = {16'b0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    op_d    = op_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && op_bad) begin
          mis_d = 1'b1;
        end else if (access) begin
          stall   = 1'b1;
          state_d = S_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = ~is_rd;
          addr_d  = addr;
          op_d    = mem_op;
          be_d    = be_new;
          wdata_d = wd_new;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.bus_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end else if (expired) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus.bus_rvalid) begin
          rdata_d = ld_ext;
          rvld_d  = 1'b1;
          state_d = S_DONE;
        end else if (expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      op_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rvld_q;
  assign misalign      = mis_q;
  assign bus_err       = err_q;
endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: directed cases plus randomized accesses checked against
// a format/latency model computed from access size, alignment and bus delays.
module tb_rv_lsu;
  localparam int TO    = 4;
  localparam int NEVER = 99;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misalign, bus_err;
  logic [31:0] rdata;
  int total, bad;

  rv_lsu_if bif();

  rv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
    .bus_err(bus_err), .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic bit m_illegal(input logic rd, input logic [2:0] op, input logic [31:0] a);
    if (op == 3 || op == 6 || op == 7) return 1;
    if (!rd && op >= 4) return 1;
    return (a % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
    int n = m_size(op);
    int v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int n = m_size(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s, mask;
    int n = m_size(op);
    s = w >> (8 * (a % 4));
    if (n == 4) return s;
    mask = (32'h1 << (8 * n)) - 1;
    s = s & mask;
    if (op < 4 && s[8*n-1]) s = s | ~mask;
    return s;
  endfunction

  // ---------------- driver: core side + bus slave, observations only --------
  task automatic run_access(
    input logic rd, wr, input logic [2:0] op, input logic [31:0] a, wd,
    input int gnt_dly, rv_dly, input logic [31:0] rword,
    output int n_stall, n_req, n_vld, n_err, n_mis,
    output logic [31:0] o_addr, o_wdata, o_rdata, output logic [3:0] o_be,
    output logic o_we, output logic hung);
    int req_seen, wait_seen, after;
    logic in_wait, retired;
    n_stall = 0; n_req = 0; n_vld = 0; n_err = 0; n_mis = 0;
    o_addr = '0; o_wdata = '0; o_rdata = 32'h5A5A_5A5A; o_be = '0; o_we = 1'b0;
    req_seen = 0; wait_seen = 0; after = 0; in_wait = 0; retired = 0; hung = 1;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_op = op; addr = a; wdata = wd;
    bif.bus_rdata = rword;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
      if (in_wait) begin
        if (wait_seen == rv_dly) begin bif.bus_rvalid = 1'b1; in_wait = 0; end
        wait_seen++;
      end
      if (bif.bus_req) begin
        if (n_req == 0) begin
          o_addr = bif.bus_addr; o_wdata = bif.bus_wdata; o_be = bif.bus_be; o_we = bif.bus_we;
        end
        n_req++;
        if (req_seen == gnt_dly) begin
          bif.bus_gnt = 1'b1;
          if (!bif.bus_we) begin in_wait = 1; wait_seen = 0; end
        end
        req_seen++;
      end
      @(negedge clk);
      if (stall) n_stall++;
      if (rdata_valid) begin n_vld++; o_rdata = rdata; end
      if (bus_err) begin n_err++; o_rdata = rdata; end
      if (misalign) n_mis++;
      if (retired) after++;
      else if (!stall) retired = 1;
      @(posedge clk); #1;
      if (retired) begin mem_read = 0; mem_write = 0; end
      if (retired && after >= 2) begin hung = 0; break; end
    end
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if ({rdata_valid, misalign, bus_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {rdata_valid, misalign, bus_err}); end
    total++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b0) begin bad++; $display("FAIL reset_busctl got=%b want=0", {bif.bus_req, bif.bus_we, bif.bus_be}); end
    total++; if ({bif.bus_addr, bif.bus_wdata} !== 64'h0) begin bad++; $display("FAIL reset_busdata got=%h want=0", {bif.bus_addr, bif.bus_wdata}); end
    rst = 1'b0;
  endtask

  task automatic test_store();
    int ns, nr, nv, ne, nm; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, hg;
    run_access(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 0, 0, 0, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (hg) begin bad++; $display("FAIL sw_hang got=hung want=done"); end
    total++; if ({ob, owe} !== 5'b11111) begin bad++; $display("FAIL sw_be_we got=%b want=11111", {ob, owe}); end
    total++; if (oa !== 32'h1004 || ow !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_addr_data got=%h/%h want=1004/deadbeef", oa, ow); end
    total++; if (ns !== 2) begin bad++; $display("FAIL sw_stall got=%0d want=2", ns); end
    run_access(0, 1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (ob !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", ob); end
    total++; if (ow !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", ow); end
    total++; if (oa !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h want=1000", oa); end
  endtask

  task automatic test_load();
    int ns, nr, nv, ne, nm; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, hg;
    run_access(1, 0, 3'b000, 32'h2002, 0, 0, 0, 32'h80FF7F01, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (orr !== 32'hFFFFFFFF) begin bad++; $display("FAIL lb_rdata got=%h want=ffffffff", orr); end
    total++; if (nv !== 1 || ns !== 3) begin bad++; $display("FAIL lb_timing got=vld%0d/stall%0d want=1/3", nv, ns); end
    run_access(1, 0, 3'b101, 32'h2002, 0, 0, 0, 32'h80FF7F01, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (orr !== 32'h000080FF) begin bad++; $display("FAIL lhu_rdata got=%h want=000080ff", orr); end
    total++; if (nv !== 1 || ns !== 3 || ob !== 4'b1100) begin bad++; $display("FAIL lhu_timing got=vld%0d/stall%0d/be%b want=1/3/1100", nv, ns, ob); end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] as [3] = '{32'h3002, 32'h3001, 32'h3000};
    logic rds [3] = '{1'b1, 1'b0, 1'b1};
    int ns, nr, nv, ne, nm; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, hg;
    for (int i = 0; i < 3; i++) begin
      run_access(rds[i], !rds[i], ops[i], as[i], 0, 0, 0, 0, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
      total++; if (nm !== 1 || nr !== 0 || ns !== 0 || hg) begin bad++; $display("FAIL illegal%0d got=mis%0d/req%0d/stall%0d want=1/0/0", i, nm, nr, ns); end
    end
  endtask

  task automatic test_timeout();
    int ns, nr, nv, ne, nm; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, hg;
    run_access(1, 0, 3'b010, 32'h4000, 0, NEVER, 0, 0, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (ne !== 1 || nr !== TO || nv !== 0) begin bad++; $display("FAIL to_err got=err%0d/req%0d/vld%0d want=1/%0d/0", ne, nr, nv, TO); end
    total++; if (orr !== 32'h0 || ns !== TO + 1 || hg) begin bad++; $display("FAIL to_rdata got=%h/stall%0d want=0/%0d", orr, ns, TO + 1); end
    run_access(0, 1, 3'b010, 32'h4004, 32'h1234, TO - 1, 0, 0, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
    total++; if (ne !== 0 || nr !== TO || ns !== TO + 1 || hg) begin bad++; $display("FAIL late_gnt got=err%0d/req%0d/stall%0d want=0/%0d/%0d", ne, nr, ns, TO, TO + 1); end
  endtask

  task automatic test_back_to_back();
    logic exp_st [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] a2;
    a2 = 'x;
    @(posedge clk); #1;
    mem_write = 1; mem_read = 0; mem_op = 3'b010; addr = 32'h100; wdata = 32'h11;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin addr = 32'h200; wdata = 32'h22; end
      bif.bus_gnt = bif.bus_req;
      if (i == 4) a2 = bif.bus_addr;
      @(negedge clk);
      total++; if (stall !== exp_st[i]) begin bad++; $display("FAIL b2b_stall%0d got=%b want=%b", i, stall, exp_st[i]); end
      @(posedge clk); #1;
    end
    mem_write = 0; bif.bus_gnt = 0;
    total++; if (a2 !== 32'h200) begin bad++; $display("FAIL b2b_addr got=%h want=200", a2); end
  endtask

  task automatic test_reset_wait();
    @(posedge clk); #1;
    mem_read = 1; mem_op = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    bif.bus_gnt = bif.bus_req;
    @(posedge clk); #1;
    bif.bus_gnt = 0; rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if (stall !== 1'b0 || bif.bus_req !== 1'b0) begin bad++; $display("FAIL rstwait_idle got=stall%b/req%b want=0/0", stall, bif.bus_req); end
    @(posedge clk); #1;
    bif.bus_rvalid = 0;
    @(negedge clk);
    total++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL rstwait_rvalid got=%b/%h want=0/0", rdata_valid, rdata); end
  endtask

  task automatic test_random();
    int ns, nr, nv, ne, nm; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, hg;
    logic rd, wr, ill, err; logic [2:0] op; logic [31:0] a, wd, w;
    int g, rv, kind, e_stall, e_req;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      rd = (kind <= 4) || (kind == 9);
      wr = (kind >= 5);
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      a = $urandom; wd = $urandom; w = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = a[1:0] & ~2'(m_size(op) - 1);
      if (rd) begin
        g = $urandom_range(0, 1); rv = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) g = NEVER;
      end else begin
        g = $urandom_range(0, 4); rv = 0;
        if (g == 4) g = NEVER;
      end
      ill = m_illegal(rd, op, a);
      err = !ill && (g >= TO);
      e_req = ill ? 0 : (err ? TO : g + 1);
      e_stall = ill ? 0 : (err ? TO + 1 : 1 + (g + 1) + (rd ? rv + 1 : 0));
      run_access(rd, wr, op, a, wd, g, rv, w, ns, nr, nv, ne, nm, oa, ow, orr, ob, owe, hg);
      total++; if (hg) begin bad++; $display("FAIL rnd%0d_hang got=hung want=done", t); end
      total++; if (nm !== int'(ill) || ne !== int'(err) || nv !== int'(rd && !ill && !err)) begin
        bad++; $display("FAIL rnd%0d_flags got=mis%0d/err%0d/vld%0d want=%0d/%0d/%0d", t, nm, ne, nv, ill, err, rd && !ill && !err);
      end
      total++; if (ns !== e_stall || nr !== e_req) begin bad++; $display("FAIL rnd%0d_timing got=stall%0d/req%0d want=%0d/%0d", t, ns, nr, e_stall, e_req); end
      if (!ill) begin
        total++; if (oa !== (a & ~32'h3) || ob !== m_be(op, a) || owe !== !rd) begin
          bad++; $display("FAIL rnd%0d_req got=%h/%b/%b want=%h/%b/%b", t, oa, ob, owe, a & ~32'h3, m_be(op, a), !rd);
        end
        if (!rd) begin
          total++; if (ow !== m_wdata(op, wd)) begin bad++; $display("FAIL rnd%0d_wdata got=%h want=%h", t, ow, m_wdata(op, wd)); end
        end
        if (err) begin
          total++; if (orr !== 32'h0) begin bad++; $display("FAIL rnd%0d_errdata got=%h want=0", t, orr); end
        end else if (rd) begin
          total++; if (orr !== m_rdata(op, a, w)) begin bad++; $display("FAIL rnd%0d_rdata got=%h want=%h", t, orr, m_rdata(op, a, w)); end
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1; mem_read = 0; mem_write = 0; mem_op = 0; addr = 0; wdata = 0;
    bif.bus_gnt = 0; bif.bus_rvalid = 0; bif.bus_rdata = 0;
    test_reset();
    test_store();
    test_load();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
